ysyx_22040750_axi_sram_slave: RTL

YSYX_22040750_AXI_SRAM_SLAVE -- requirements
Module: ysyx_22040750_axi_sram_slave

---
 rtl/ysyx_22040750_axi_sram_slave.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040750_axi_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040750_axi_sram_slave
//  Description : Single-outstanding AXI4-style SRAM slave backed by a
//                2^AW_IDX x 64-bit memory mapped at BASE. Every beat is a
//                full 64-bit INCR beat. Addresses outside the window get
//                DECERR (2'b11) and never touch memory.
//  Ports       : I_clk / I_rst_n            - clock, async active-low reset
//                AW  (I_awvalid..I_awlen)   - write address channel
//                W   (I_wvalid..I_wlast)    - write data channel
//                B   (O_bvalid..O_bresp)    - write response channel
//                AR  (I_arvalid..I_arlen)   - read address channel
//                R   (O_rvalid..O_rlast)    - read data channel
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22040750_axi_sram_slave #(
  parameter int          AW_IDX = 6,
  parameter logic [31:0] BASE   = 32'h8000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  // write address
  input  logic        I_awvalid,
  output logic        O_awready,
  input  logic [3:0]  I_awid,
  input  logic [31:0] I_awaddr,
  input  logic [7:0]  I_awlen,
  // write data
  input  logic        I_wvalid,
  output logic        O_wready,
  input  logic [63:0] I_wdata,
  input  logic [7:0]  I_wstrb,
  input  logic        I_wlast,
  // write response
  output logic        O_bvalid,
  input  logic        I_bready,
  output logic [3:0]  O_bid,
  output logic [1:0]  O_bresp,
  // read address
  input  logic        I_arvalid,
  output logic        O_arready,
  input  logic [3:0]  I_arid,
  input  logic [31:0] I_araddr,
  input  logic [7:0]  I_arlen,
  // read data
  output logic        O_rvalid,
  input  logic        I_rready,
  output logic [3:0]  O_rid,
  output logic [1:0]  O_rresp,
  output logic [63:0] O_rdata,
  output logic        O_rlast
);

  localparam int c_TAG_LSB = AW_IDX + 3;
  localparam int c_DEPTH   = 1 << AW_IDX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WRESP = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_live;   // low during reset and for the first edge after release
  logic [7:0]          r_len;
  logic [7:0]          r_cnt;
  logic [AW_IDX-1:0]   r_idx;
  logic                r_hit;
  logic                r_err;
  logic [3:0]          r_id;
  logic [63:0]         r_mem [c_DEPTH];

  logic w_idle;
  logic w_last_beat;
  logic w_wr_beat;
  logic w_unused_ok;

  assign w_idle      = (r_state == S_IDLE) && r_live;
  assign w_last_beat = (r_cnt == r_len);
  assign w_wr_beat   = (r_state == S_WDATA) && I_wvalid;
  // Byte offset within a 64-bit word is irrelevant: every beat is full width.
  assign w_unused_ok = ^{I_awaddr[2:0], I_araddr[2:0]};

  // Reads win when both address channels are presented in the same cycle.
  assign O_arready = w_idle;
  assign O_awready = w_idle && !I_arvalid;
  assign O_wready  = (r_state == S_WDATA);
  assign O_bvalid  = (r_state == S_WRESP);
  assign O_bid     = (r_state == S_WRESP) ? r_id : 4'd0;
  assign O_bresp   = (r_state != S_WRESP) ? 2'b00 :
                     !r_hit               ? 2'b11 :
                     r_err                ? 2'b10 : 2'b00;
  assign O_rvalid  = (r_state == S_RDATA);
  assign O_rid     = (r_state == S_RDATA) ? r_id : 4'd0;
  assign O_rresp   = (r_state == S_RDATA && !r_hit) ? 2'b11 : 2'b00;
  // Driven purely from held state, so it cannot change while stalled.
  assign O_rdata   = (r_state == S_RDATA && r_hit) ? r_mem[r_idx] : 64'd0;
  assign O_rlast   = (r_state == S_RDATA) && w_last_beat;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_idx   <= '0;
      r_hit   <= 1'b0;
      r_err   <= 1'b0;
      r_id    <= 4'd0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_live && I_arvalid) begin
            r_id    <= I_arid;
            r_len   <= I_arlen;
            r_idx   <= I_araddr[c_TAG_LSB-1:3];
            r_hit   <= (I_araddr[31:c_TAG_LSB] == BASE[31:c_TAG_LSB]);
            r_cnt   <= 8'd0;
            r_state <= S_RDATA;
          end else if (r_live && I_awvalid) begin
            r_id    <= I_awid;
            r_len   <= I_awlen;
            r_idx   <= I_awaddr[c_TAG_LSB-1:3];
            r_hit   <= (I_awaddr[31:c_TAG_LSB] == BASE[31:c_TAG_LSB]);
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
            r_state <= S_WDATA;
          end
        end
        S_RDATA: begin
          if (I_rready) begin
            r_cnt <= r_cnt + 8'd1;
            r_idx <= r_idx + 1'b1;
            if (w_last_beat) r_state <= S_IDLE;
          end
        end
        S_WDATA: begin
          if (I_wvalid) begin
            r_cnt <= r_cnt + 8'd1;
            r_idx <= r_idx + 1'b1;
            // wlast must coincide exactly with the final counted beat
            if (I_wlast != w_last_beat) r_err <= 1'b1;
            // The burst length is authoritative; wlast only affects the response.
            if (w_last_beat) r_state <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (I_bready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory has no reset; contents survive I_rst_n.
  always_ff @(posedge I_clk) begin
    if (w_wr_beat && r_hit) begin
      for (int k = 0; k < 8; k++) begin
        if (I_wstrb[k]) r_mem[r_idx][8*k +: 8] <= I_wdata[8*k +: 8];
      end
    end
  end

endmodule
`default_nettype wire
